phy_rx_serial_paralelo: RTL

- Receive-side deserializer for the clockless PHY link: takes the 1-bit serial stream produced by the transmit path and recovers byte alignment using the idle comma (0xBC).
- Declares the link active after a run of consecutive commas, then delivers data bytes with a valid flag.
- Sits at the far end of the serial lane, ahead of the byte un-striping logic that rebuilds lanes 0/1.
- Runs in the clk_8f domain, one serial bit per cycle.

---
 rtl/phy_rx_serial_paralelo.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/phy_rx_serial_paralelo.sv
// Serial-to-parallel receiver: locks byte alignment on a run of idle commas, then emits bytes.
// Define PHY_RX_STATS_EN to add the rx_byte_count / rx_idle_count statistics outputs.
module phy_rx_serial_paralelo #(
    parameter logic [7:0]  COMMA       = 8'hBC,
    parameter int unsigned ALIGN_COUNT = 4
) (
    input  logic        clk_8f,
    input  logic        reset,
    input  logic        data_in,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic        byte_strobe,
    output logic        active,
    output logic [3:0]  comma_cnt
`ifdef PHY_RX_STATS_EN
    ,
    output logic [15:0] rx_byte_count,
    output logic [15:0] rx_idle_count
`endif
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] ALIGN_TARGET = 4'(ALIGN_COUNT);

    state_t     r_state, w_state_nxt;
    logic [6:0] r_sr;
    logic [2:0] r_bit_cnt, w_bit_cnt_nxt;
    logic [3:0] r_comma_cnt, w_comma_cnt_nxt;
    logic [7:0] r_data, w_data_nxt;
    logic       r_valid, w_valid_nxt;
    logic       r_strobe, w_strobe_nxt;
    logic       r_active, w_active_nxt;
    logic [7:0] w_cand;
    logic       w_is_comma;
    logic       w_boundary;
`ifdef PHY_RX_STATS_EN
    logic [15:0] r_byte_count, w_byte_count_nxt;
    logic [15:0] r_idle_count, w_idle_count_nxt;
`endif

    // The candidate byte always ends with the bit arriving this cycle.
    assign w_cand     = {r_sr, data_in};
    assign w_is_comma = (w_cand == COMMA);
    assign w_boundary = (r_bit_cnt == 3'd7);

    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_comma_cnt_nxt = r_comma_cnt;
        w_data_nxt      = r_data;
        w_valid_nxt     = r_valid;
        w_strobe_nxt    = 1'b0;
        w_active_nxt    = r_active;
`ifdef PHY_RX_STATS_EN
        w_byte_count_nxt = r_byte_count;
        w_idle_count_nxt = r_idle_count;
`endif
        case (r_state)
            ST_SEARCH: begin
                if (w_is_comma) begin
                    w_bit_cnt_nxt   = 3'd0;
                    w_comma_cnt_nxt = 4'd1;
                    if (ALIGN_TARGET == 4'd1) begin
                        w_state_nxt  = ST_ACTIVE;
                        w_active_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_ALIGN;
                    end
                end
            end
            ST_ALIGN: begin
                w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                if (w_boundary) begin
                    if (w_is_comma) begin
                        w_comma_cnt_nxt = r_comma_cnt + 4'd1;
                        if ((r_comma_cnt + 4'd1) == ALIGN_TARGET) begin
                            w_state_nxt  = ST_ACTIVE;
                            w_active_nxt = 1'b1;
                        end
                    end else begin
                        w_comma_cnt_nxt = 4'd0;
                        w_state_nxt     = ST_SEARCH;
                    end
                end
            end
            ST_ACTIVE: begin
                // Alignment is frozen here; commas straddling bytes are never re-examined.
                w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                if (w_boundary) begin
                    w_data_nxt   = w_cand;
                    w_valid_nxt  = !w_is_comma;
                    w_strobe_nxt = 1'b1;
                    if (w_is_comma) begin
                        if (r_comma_cnt != 4'd15) w_comma_cnt_nxt = r_comma_cnt + 4'd1;
                    end else begin
                        w_comma_cnt_nxt = 4'd0;
                    end
`ifdef PHY_RX_STATS_EN
                    if (!w_is_comma && r_byte_count != 16'hFFFF) w_byte_count_nxt = r_byte_count + 16'd1;
                    if (w_is_comma && r_idle_count != 16'hFFFF) w_idle_count_nxt = r_idle_count + 16'd1;
`endif
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_8f) begin
        if (!reset) begin
            r_state     <= ST_SEARCH;
            r_sr        <= 7'd0;
            r_bit_cnt   <= 3'd0;
            r_comma_cnt <= 4'd0;
            r_data      <= 8'd0;
            r_valid     <= 1'b0;
            r_strobe    <= 1'b0;
            r_active    <= 1'b0;
`ifdef PHY_RX_STATS_EN
            r_byte_count <= 16'd0;
            r_idle_count <= 16'd0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_sr        <= w_cand[6:0];
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_comma_cnt <= w_comma_cnt_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_strobe    <= w_strobe_nxt;
            r_active    <= w_active_nxt;
`ifdef PHY_RX_STATS_EN
            r_byte_count <= w_byte_count_nxt;
            r_idle_count <= w_idle_count_nxt;
`endif
        end
    end

    assign data_out    = r_data;
    assign valid_out   = r_valid;
    assign byte_strobe = r_strobe;
    assign active      = r_active;
    assign comma_cnt   = r_comma_cnt;
`ifdef PHY_RX_STATS_EN
    assign rx_byte_count = r_byte_count;
    assign rx_idle_count = r_idle_count;
`endif

endmodule
